// File: rtl/regfile_2r1w_clr.sv
// Two-read/one-write register file with write-first bypass and a one-entry-per-cycle clear sequencer.
// Optional feature: define RF_ZERO_REG_EN to hardwire entry 0 to zero.
module regfile_2r1w_clr #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr_req,
  output logic              clr_busy
);

`ifdef RF_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DATA_W-1:0]   rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0]   rdata_b_q, rdata_b_d;

  logic                a_valid, b_valid, w_valid, wr_en;
  logic [DATA_W-1:0]   rd_a, rd_b;

  // An address is usable when in range and not the hardwired-zero entry.
  assign a_valid = ({1'b0, raddr_a} < DEPTH_L) && !(ZERO_REG && raddr_a == '0);
  assign b_valid = ({1'b0, raddr_b} < DEPTH_L) && !(ZERO_REG && raddr_b == '0);
  assign w_valid = ({1'b0, waddr}   < DEPTH_L) && !(ZERO_REG && waddr   == '0);
  assign wr_en   = we && (state_q == ST_IDLE) && w_valid;

  assign rd_a = a_valid ? mem_q[raddr_a] : '0;
  assign rd_b = b_valid ? mem_q[raddr_b] : '0;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    mem_d     = mem_q;
    state_d   = state_q;
    ptr_d     = ptr_q;
    rdata_a_d = '0;
    rdata_b_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        rdata_a_d = (wr_en && raddr_a == waddr) ? wdata : rd_a;
        rdata_b_d = (wr_en && raddr_b == waddr) ? wdata : rd_b;
        if (wr_en) mem_d[waddr] = wdata;
        if (clr_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        // Reads return zero and writes are dropped for the whole sequence.
        mem_d[ptr_q] = '0;
        if (ptr_q == LAST_IDX) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the storage array is reset here because reset must leave every entry reading zero;
  // most register files skip this and rely on a clear sequence instead.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      mem_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      mem_q     <= mem_d;
    end
  end

  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;
  assign clr_busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// Self-checking bench for regfile_2r1w_clr: directed scenarios plus random traffic against
// an array-based reference model.
module tb_regfile_2r1w_clr;
  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] raddr_a, raddr_b, waddr;
  logic [DW-1:0] wdata;
  logic          we, clr_req;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          clr_busy;

  regfile_2r1w_clr #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .raddr_a(raddr_a), .rdata_a(rdata_a),
    .raddr_b(raddr_b), .rdata_b(rdata_b),
    .we(we), .waddr(waddr), .wdata(wdata),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

`ifdef RF_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: plain array, a busy flag and a remaining-cycle count.
  logic [DW-1:0] model [DEPTH];
  bit            m_busy;
  int            m_left;
  logic [DW-1:0] exp_a, exp_b;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (int'(a) >= DEPTH || (ZERO_REG && a == 0)) return '0;
    return model[a];
  endfunction

  task automatic model_reset();
    foreach (model[i]) model[i] = '0;
    m_busy = 1'b0;
    m_left = 0;
    exp_a  = '0;
    exp_b  = '0;
  endtask

  // One clock edge of the specified behaviour; clearing empties the array at once
  // since nothing can observe entries while the sequence runs.
  task automatic model_edge();
    bit wr;
    if (m_busy) begin
      exp_a = '0;
      exp_b = '0;
      m_left--;
      if (m_left == 0) m_busy = 1'b0;
    end else begin
      wr    = we && int'(waddr) < DEPTH && !(ZERO_REG && waddr == 0);
      exp_a = (wr && raddr_a == waddr) ? wdata : m_read(raddr_a);
      exp_b = (wr && raddr_b == waddr) ? wdata : m_read(raddr_b);
      if (wr) model[waddr] = wdata;
      if (clr_req) begin
        m_busy = 1'b1;
        m_left = DEPTH;
        foreach (model[i]) model[i] = '0;
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, "_rdata_a"}, 32'(rdata_a), 32'(exp_a));
    check({tag, "_rdata_b"}, 32'(rdata_b), 32'(exp_b));
    check({tag, "_busy"},    32'(clr_busy), 32'(m_busy));
  endtask

  task automatic idle_in();
    we = 1'b0; clr_req = 1'b0; waddr = '0; wdata = '0;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input string tag);
    we = 1'b1; waddr = AW'(a); wdata = d;
    step(tag);
    we = 1'b0;
  endtask

  task automatic mid_cycle_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_rst_a"},    32'(rdata_a),  0);
    check({tag, "_rst_b"},    32'(rdata_b),  0);
    check({tag, "_rst_busy"}, 32'(clr_busy), 0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    int n_busy;
    rst_n = 1'b0; raddr_a = '0; raddr_b = '0;
    idle_in();
    model_reset();
    #12 rst_n = 1'b1;

    // Reset: dirty the array, reset mid-cycle, then read every address.
    wr(1, 8'h33, "pre");
    raddr_a = 1; step("pre_rd");
    check("pre_val", 32'(rdata_a), 32'h33);
    mid_cycle_reset("t1");
    for (int i = 0; i < DEPTH; i++) begin
      raddr_a = AW'(i); raddr_b = AW'(DEPTH - 1 - i);
      step("t1_rd");
    end

    // Write then read on both ports.
    raddr_a = 0; raddr_b = 0;
    wr(5, 8'hA5, "t2_wr");
    raddr_a = 5; raddr_b = 5; step("t2_rd");
    check("t2_a5_a", 32'(rdata_a), 32'hA5);
    check("t2_a5_b", 32'(rdata_b), 32'hA5);
    raddr_a = 6; step("t2_rd6");
    check("t2_e6", 32'(rdata_a), 0);

    // Write-first bypass on port A only.
    wr(9, 8'h11, "t3_w9");
    wr(8, 8'h22, "t3_w8");
    raddr_a = 9; raddr_b = 8;
    wr(9, 8'h3C, "t3_byp");
    check("t3_byp_a", 32'(rdata_a), 32'h3C);
    check("t3_byp_b", 32'(rdata_b), 32'h22);

    // Clear sequence with a write attempted mid-clear.
    for (int i = 0; i < DEPTH; i++) wr(i, 8'hFF, "t4_fill");
    clr_req = 1'b1; step("t4_req"); clr_req = 1'b0;
    n_busy = 0;
    for (int g = 0; g < 40 && clr_busy; g++) begin
      n_busy++;
      if (g == 10) begin we = 1'b1; waddr = 3; wdata = 8'h77; end
      else we = 1'b0;
      step("t4_clr");
    end
    we = 1'b0;
    check("t4_busy_cycles", 32'(n_busy), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      raddr_a = AW'(i); raddr_b = AW'(i);
      step("t4_rd");
      if (i == 3) check("t4_e3", 32'(rdata_a), 0);
    end

    // Reset during the clear sequence.
    clr_req = 1'b1; step("t5_req"); clr_req = 1'b0;
    for (int i = 0; i < 10; i++) step("t5_clr");
    mid_cycle_reset("t5");
    wr(2, 8'h42, "t5_wr");
    raddr_a = 2; step("t5_rd");
    check("t5_e2", 32'(rdata_a), 32'h42);

    // Entry 0 with a bypassing write.
    raddr_a = 0; raddr_b = 1;
    wr(0, 8'h5A, "t6_wr0");
    check("t6_byp0", 32'(rdata_a), ZERO_REG ? 0 : 32'h5A);
    step("t6_rd0");
    check("t6_rd0_val", 32'(rdata_a), ZERO_REG ? 0 : 32'h5A);

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      we      = ($urandom_range(0, 1) == 1);
      waddr   = AW'($urandom_range(0, DEPTH - 1));
      wdata   = DW'($urandom);
      clr_req = ($urandom_range(0, 63) == 0);
      raddr_a = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, DEPTH - 1));
      raddr_b = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, DEPTH - 1));
      step("rnd");
    end
    idle_in();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
